// File: rtl/fifo_pkg.sv
// Shared constants and the commit/discard decode for the packet FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 32'd8;
    localparam int DEF_DEPTH  = 32'd64;

    typedef enum logic [1:0] {
        WR_HOLD    = 2'd0,
        WR_COMMIT  = 2'd1,
        WR_DISCARD = 2'd2
    } wr_action_t;

    // A CRC failure must never be published, so discard outranks commit.
    function automatic wr_action_t decode_wr_action(input logic commit, input logic discard);
        wr_action_t act;
        if (discard) begin
            act = WR_DISCARD;
        end else if (commit) begin
            act = WR_COMMIT;
        end else begin
            act = WR_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: clear beats load, load beats increment.
module fifo_ptr #(
    parameter int PTR_W = 32'd7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             inc,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Pointer update with flush and rollback priority.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr <= '0;
        end else if (clear) begin
            r_ptr <= '0;
        end else if (load) begin
            r_ptr <= load_val;
        end else if (inc) begin
            r_ptr <= r_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/pkt_flex_fifo.sv
// Packet FIFO: writes stay tentative until committed, and can be rolled back on discard.
module pkt_flex_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 32'd8,
    parameter int AE_THRESH = 32'd8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic                       w_enable,
    input  logic [DATA_W-1:0]          w_data,
    input  logic                       w_commit,
    input  logic                       w_discard,
    input  logic                       r_enable,
    output logic [DATA_W-1:0]          r_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_V    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_rd_ptr;
    logic [ADDR_W:0]   w_wr_ptr;
    logic [ADDR_W:0]   w_cm_ptr;
    logic [ADDR_W:0]   w_wr_next;
    logic [ADDR_W:0]   w_tent_occ;
    logic [ADDR_W:0]   w_cm_occ;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_inc;
    logic              w_wr_load;
    logic              w_cm_load;
    wr_action_t        w_action;

    assign w_tent_occ = w_wr_ptr - w_rd_ptr;
    assign w_cm_occ   = w_cm_ptr - w_rd_ptr;
    assign full       = (w_tent_occ == DEPTH_V);
    assign empty      = (w_cm_occ == '0);
    assign w_wr_acc   = w_enable & ~full & ~clear;
    assign w_rd_acc   = r_enable & ~empty & ~clear;
    // Commit captures the post-increment pointer so a same-cycle write is published too.
    assign w_wr_next  = w_wr_ptr + (ADDR_W+1)'(w_wr_acc);

    // Decode commit/discard into pointer controls.
    always_comb begin
        w_action  = decode_wr_action(w_commit, w_discard);
        w_wr_inc  = w_wr_acc;
        w_wr_load = 1'b0;
        w_cm_load = 1'b0;
        case (w_action)
            WR_DISCARD: begin
                w_wr_inc  = 1'b0;
                w_wr_load = 1'b1;
            end
            WR_COMMIT: begin
                w_cm_load = 1'b1;
            end
            default: begin
                w_wr_load = 1'b0;
            end
        endcase
    end

    fifo_ptr #(.PTR_W(ADDR_W+1)) u_rd_ptr (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .inc(w_rd_acc), .load(1'b0), .load_val('0), .ptr(w_rd_ptr)
    );

    fifo_ptr #(.PTR_W(ADDR_W+1)) u_wr_ptr (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .inc(w_wr_inc), .load(w_wr_load), .load_val(w_cm_ptr), .ptr(w_wr_ptr)
    );

    fifo_ptr #(.PTR_W(ADDR_W+1)) u_cm_ptr (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .inc(1'b0), .load(w_cm_load), .load_val(w_wr_next), .ptr(w_cm_ptr)
    );

    // Storage write; a write dropped by discard leaves memory untouched.
    always_ff @(posedge clk) begin
        if (w_wr_inc) begin
            r_mem[w_wr_ptr[ADDR_W-1:0]] <= w_data;
        end
    end

    // Single-cycle error pulses for rejected operations.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_enable & full;
            r_underflow <= r_enable & empty;
        end
    end

    assign r_data       = r_mem[w_rd_ptr[ADDR_W-1:0]];
    assign count        = w_cm_occ;
    assign almost_full  = (w_tent_occ >= AF_V);
    assign almost_empty = (w_cm_occ <= AE_V);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/pkt_flex_fifo.md
Name: pkt_flex_fifo

Overview:
Parametrised, power-of-two-depth packet FIFO used to hold USB payload bytes ahead of the AES datapath. Data is written tentatively and becomes readable only when the writer commits the packet. A packet that fails its CRC is discarded by rolling the write pointer back. It adds occupancy count, almost-full/almost-empty flags, a synchronous flush and overflow/underflow reporting.

Parameters:
DATA_W, 8, width of each FIFO word in bits.
DEPTH, 64, number of entries; must be a power of two and at least 4.
AF_THRESH, DEPTH-8, almost_full asserts when tentative occupancy is at least this value.
AE_THRESH, 8, almost_empty asserts when committed occupancy is at most this value.
(localparam) ADDR_W, $clog2(DEPTH); pointers are ADDR_W+1 bits wide, the extra MSB being the wrap bit.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush of all pointers.
w_enable  input  1  write request.
w_data  input  DATA_W  write data.
w_commit  input  1  publish all tentative writes, including a write accepted in the same cycle.
w_discard  input  1  drop all uncommitted writes.
r_enable  input  1  read/pop request.
r_data  output  DATA_W  head word, first-word-fall-through.
empty  output  1  no committed data available.
full  output  1  no free entry; tentative data is counted as occupying space.
almost_full  output  1  tentative occupancy >= AF_THRESH.
almost_empty  output  1  committed occupancy <= AE_THRESH.
count  output  ADDR_W+1  committed occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse: write was attempted while full.
underflow  output  1  one-cycle pulse: read was attempted while empty.

Behaviour:
- One clock domain (clk). Asynchronous, active-low reset (n_rst). Reset values:
  - Pointers rd_ptr, wr_ptr and cm_ptr = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.
  - Memory array is not reset. r_data is don't-care whenever empty=1.
- Occupancy:
  - tent_occ = wr_ptr - rd_ptr.
  - count = cm_ptr - rd_ptr.
  - Both use modulo 2^(ADDR_W+1) arithmetic.
  - All flags are derived only from registered pointers, so they are glitch-free with no input-to-flag combinational path.
- Flags: full = (tent_occ == DEPTH); empty = (count == 0).
- Write:
  - Accepted when w_enable && !full.
  - mem[wr_ptr[ADDR_W-1:0]] <= w_data; wr_ptr increments at the same edge.
- Commit: cm_ptr <= post-increment wr_ptr. A write and its commit can share one cycle.
- Discard:
  - wr_ptr <= cm_ptr. A same-cycle write is dropped and memory is unchanged.
  - Discard wins over commit when both are asserted.
- Read:
  - Accepted when r_enable && !empty; rd_ptr increments.
  - r_data = mem[rd_ptr[ADDR_W-1:0]], combinational from registered state, with zero read latency.
- Visibility latency: a word committed at edge N is readable (empty=0, r_data valid) immediately after edge N.
- A simultaneous accepted read and write is always legal, including at full-1 and at count=1.
- A read never passes cm_ptr, so uncommitted data is never visible.
- Errors:
  - overflow <= w_enable && full, registered and high for one cycle.
  - underflow <= r_enable && empty, likewise.
  - The rejected operation has no other effect.
- clear:
  - Highest priority below reset.
  - All three pointers go to 0 at the edge, and w_enable, r_enable, w_commit and w_discard are ignored in that cycle.
  - overflow and underflow read 0 in the following cycle.
- Wrap-around: pointers wrap naturally through 2^(ADDR_W+1). full versus empty is resolved by the MSB, so DEPTH entries are usable.
- Reset mid-packet: all tentative and committed data is lost, and the FIFO returns to its reset values.

Decomposition:
- fifo_pkg:
  - Default constants DEF_DATA_W=8 and DEF_DEPTH=64.
  - typedef enum logic [1:0] {WR_HOLD, WR_COMMIT, WR_DISCARD} wr_action_t, the decoded commit/discard priority.
- Sub-module fifo_ptr: ADDR_W+1-bit pointer register with ports clk, n_rst, clear, inc, load and load_val.
  - Instanced three times: rd, wr, cm.
  - cm uses load only; wr uses inc and load.

Test Plan:
1. Reset, then write 0x11,0x22,0x33 with no commit -> empty=1, count=0. Then one w_commit -> next cycle empty=0, count=3, r_data=0x11.
2. Write 0xA0..0xA4 and discard in the cycle of the 0xA4 write -> count unchanged at 0, empty=1. A following write of 0x55 plus commit -> r_data=0x55.
3. DEPTH=64: write and commit 64 words -> full=1, almost_full=1, count=64. A 65th write -> overflow pulses for 1 cycle and count stays 64. Pop all 64 -> data in order, then empty=1.
4. Run 200 words with continuous simultaneous read/write/commit -> pointers wrap 3+ times with no loss and no duplication; count stays constant.
5. r_enable while empty -> underflow=1 for exactly one cycle; rd_ptr is unchanged.
6. Hold 10 committed words and 4 tentative ones, then assert clear together with w_commit -> next cycle count=0, empty=1, full=0, almost_empty=1, overflow=0, underflow=0.
